// File: rtl/qc_ldpc_lambda_accum.sv
// QC-LDPC lambda accumulator: XOR-folds cyclically shifted info sub-blocks into
// one register per parity row, then streams the parity-row lambdas downstream.
module qc_ldpc_lambda_accum #(
    parameter int ZMAX            = 81,
    parameter int NUM_INFO_BLKS   = 20,
    parameter int NUM_PARITY_BLKS = 4,
    parameter int SW              = $clog2(ZMAX),
    parameter int CW              = $clog2(NUM_INFO_BLKS),
    localparam int RW             = (NUM_PARITY_BLKS > 1) ? $clog2(NUM_PARITY_BLKS) : 1
) (
    input  logic                          CLK,
    input  logic                          rst_n,
    input  logic [1:0]                    z_sel,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [ZMAX-1:0]               s_data,
    output logic [CW-1:0]                 rom_col,
    input  logic [NUM_PARITY_BLKS*SW-1:0] rom_shift,
    input  logic [NUM_PARITY_BLKS-1:0]    rom_null,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [ZMAX-1:0]               m_data,
    output logic [RW-1:0]                 m_row,
    output logic                          m_last,
    output logic                          err
);

    localparam int ZW = $clog2(ZMAX + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]      r_state;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [ZW-1:0]   r_z;
    logic [ZMAX-1:0] r_acc [NUM_PARITY_BLKS];
    logic [ZMAX-1:0] r_mData;
    logic            r_mLast;
    logic            r_err;

    logic [ZW-1:0]   w_zSel;
    logic [ZW-1:0]   w_z;
    logic [ZMAX-1:0] w_mask;
    logic [ZW-1:0]   w_shift [NUM_PARITY_BLKS];
    logic [ZMAX-1:0] w_accNext [NUM_PARITY_BLKS];
    logic            w_beatErr;
    logic            w_accept;
    logic            w_mFire;
    logic            w_lastCol;
    logic            w_lastRow;

    // z_sel=3 is illegal and falls back to the widest circulant.
    function automatic logic [ZW-1:0] zDecode(input logic [1:0] sel);
        case (sel)
            2'd0:    zDecode = ZW'(ZMAX / 3);
            2'd1:    zDecode = ZW'((2 * ZMAX) / 3);
            default: zDecode = ZW'(ZMAX);
        endcase
    endfunction

    // Cyclic rotation that wraps at Z rather than ZMAX; requires s < z.
    function automatic logic [ZMAX-1:0] rotZ(input logic [ZMAX-1:0] u,
                                             input logic [ZW-1:0]   s,
                                             input logic [ZW-1:0]   z,
                                             input logic [ZMAX-1:0] mask);
        logic [ZMAX-1:0] um;
        um   = u & mask;
        rotZ = ((um >> s) | (um << (z - s))) & mask;
    endfunction

    assign w_zSel    = zDecode(z_sel);
    assign w_z       = (r_state == S_IDLE) ? w_zSel : r_z;
    assign w_mask    = ~({ZMAX{1'b1}} << w_z);
    assign s_ready   = rst_n && (r_state != S_DRAIN);
    assign m_valid   = (r_state == S_DRAIN);
    assign w_accept  = s_valid && s_ready;
    assign w_mFire   = m_valid && m_ready;
    assign w_lastCol = (r_col == CW'(NUM_INFO_BLKS - 1));
    assign w_lastRow = (r_row == RW'(NUM_PARITY_BLKS - 1));
    assign rom_col   = r_col;
    assign m_data    = r_mData;
    assign m_row     = r_row;
    assign m_last    = r_mLast;
    assign err       = r_err;

    for (genvar g = 0; g < NUM_PARITY_BLKS; g++) begin : g_shift
        assign w_shift[g] = ZW'(rom_shift[g*SW +: SW]);
    end

    // The first beat of a frame seeds the accumulators instead of folding into them.
    always_comb begin
        w_beatErr = (r_state == S_IDLE) && (z_sel == 2'd3);
        for (int i = 0; i < NUM_PARITY_BLKS; i++) begin
            w_accNext[i] = (r_state == S_IDLE) ? '0 : r_acc[i];
            if (!rom_null[i]) begin
                if (w_shift[i] < w_z) begin
                    w_accNext[i] = w_accNext[i] ^ rotZ(s_data, w_shift[i], w_z, w_mask);
                end else begin
                    w_beatErr = 1'b1;
                end
            end
        end
    end

    // In IDLE the column counter is zero, so w_lastCol also covers single-column frames.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_z     <= '0;
            r_mData <= '0;
            r_mLast <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < NUM_PARITY_BLKS; i++) begin
                r_acc[i] <= '0;
            end
        end else if (r_state != S_DRAIN) begin
            if (w_accept) begin
                for (int i = 0; i < NUM_PARITY_BLKS; i++) begin
                    r_acc[i] <= w_accNext[i];
                end
                if (r_state == S_IDLE) begin
                    r_z   <= w_zSel;
                    r_err <= w_beatErr;
                end else begin
                    r_err <= r_err | w_beatErr;
                end
                if (w_lastCol) begin
                    r_state <= S_DRAIN;
                    r_col   <= '0;
                    r_mData <= w_accNext[0];
                    r_mLast <= (NUM_PARITY_BLKS == 1);
                end else begin
                    r_state <= S_ACCUM;
                    r_col   <= r_col + 1'b1;
                end
            end
        end else if (w_mFire) begin
            if (w_lastRow) begin
                r_state <= S_IDLE;
                r_row   <= '0;
                r_mData <= '0;
                r_mLast <= 1'b0;
                for (int i = 0; i < NUM_PARITY_BLKS; i++) begin
                    r_acc[i] <= '0;
                end
            end else begin
                r_row   <= r_row + 1'b1;
                r_mData <= r_acc[r_row + 1'b1];
                r_mLast <= ((r_row + 1'b1) == RW'(NUM_PARITY_BLKS - 1));
            end
        end
    end

endmodule
